mem_ctrl_unit: RTL
==================

MEM_CTRL_UNIT -- requirements
Module: mem_ctrl_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 8, meaning the maximum number of ACCESS cycles allowed before timeout (legal 1..255).
REQ-002 SHALL have port Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port Bus_In  input  16  datapath bus value, produced by the 4:1 16-bit bus mux.
REQ-005 SHALL have port LD_MAR  input  1  load MAR from Bus_In.
REQ-006 SHALL have port LD_MDR  input  1  load MDR from Bus_In.
REQ-007 SHALL have port Mem_Req  input  1  start one memory access; level is sampled in IDLE only.
REQ-008 SHALL have port Mem_Wr  input  1  access type, sampled with Mem_Req (1 = write, 0 = read).
REQ-009 SHALL have port Mem_RData  input  16  read data from memory.
REQ-010 SHALL have port Mem_Ready  input  1  memory completion strobe.
REQ-011 SHALL have port MAR  output  16  memory address register.
REQ-012 SHALL have port MDR  output  16  memory data register; fed back to the bus mux.
REQ-013 SHALL have port Mem_Addr  output  16  equals MAR.
REQ-014 SHALL have port Mem_WData  output  16  equals MDR.
REQ-015 SHALL have port Mem_CE  output  1  chip enable; high in ACCESS only.
REQ-016 SHALL have port Mem_WE  output  1  write enable; high in ACCESS for write ops only.
REQ-017 SHALL have port Busy  output  1  high whenever state is not IDLE.
REQ-018 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-019 SHALL have port Err  output  1  sticky timeout flag.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS and DONE, all registered.
REQ-021 IDLE: Mem_Req=1 SHALL latch op = Mem_Wr, clear Err, clear the wait counter and go to ACCESS; otherwise IDLE SHALL hold.
REQ-022 ACCESS: Mem_Ready=1 SHALL go to DONE; on a read, MDR SHALL load Mem_RData on that same edge; on a write, MDR SHALL be unchanged.
REQ-023 ACCESS without Mem_Ready SHALL increment the 8-bit wait counter.
REQ-024 ACCESS timeout: if the counter equals MAX_WAIT-1 and Mem_Ready=0, the FSM SHALL set Err=1, leave MDR unchanged and go to DONE.
REQ-025 DONE: Done=1 for exactly one cycle, then the FSM SHALL go unconditionally to IDLE; Mem_Req is ignored in DONE.
REQ-026 Latency: with Mem_Ready high in the first ACCESS cycle, Done SHALL assert in the second cycle after the request edge; each wait cycle adds one.
REQ-027 LD_MAR / LD_MDR SHALL take effect only in IDLE and SHALL be ignored while Busy=1.
REQ-028 Simultaneous LD_MAR (or LD_MDR) with an accepted Mem_Req in IDLE: the register SHALL load Bus_In, and the access SHALL use the new value.
REQ-029 Mem_Addr and Mem_WData SHALL be combinational copies of MAR and MDR, stable throughout ACCESS.
REQ-030 Mem_Ready outside ACCESS SHALL be ignored.
REQ-031 Err SHALL remain set through IDLE until the next accepted Mem_Req.

Reset
REQ-032 Reset_n=0 SHALL immediately force state=IDLE, MAR=16'h0000, MDR=16'h0000, counter=0, op=0, Err=0, Done=0, Busy=0, Mem_CE=0 and Mem_WE=0, independent of Clk.
REQ-033 Reset asserted mid-ACCESS SHALL abort the access with no Done pulse, and MDR SHALL be cleared.
REQ-034 After Reset_n deasserts, the block SHALL accept Mem_Req on the first rising edge.

Verification
REQ-035 Read, zero wait: LD_MAR with Bus_In=16'h3000; Mem_Req, Mem_Wr=0; Mem_RData=16'hBEEF, Mem_Ready=1 in the first ACCESS cycle -> Mem_CE high for 1 cycle, Mem_Addr=16'h3000, MDR=16'hBEEF, Done pulses 2 cycles after the request.
REQ-036 Write, 3 wait cycles: MAR=16'h0010, MDR=16'h1234, Mem_Wr=1; Mem_Ready on the 4th ACCESS cycle -> Mem_WE/Mem_CE high for 4 cycles, Mem_WData=16'h1234, MDR unchanged, Done pulses once.
REQ-037 Timeout, MAX_WAIT=8, Mem_Ready never asserted -> Mem_CE high for 8 cycles, Err=1, MDR unchanged, Done pulses; the next Mem_Req clears Err.
REQ-038 Same-edge load plus request: LD_MAR=1, Bus_In=16'h00FF and Mem_Req=1 in IDLE -> Mem_Addr=16'h00FF throughout ACCESS.
REQ-039 Busy interference: LD_MAR and LD_MDR pulsed with Bus_In=16'hFFFF, plus a Mem_Req, during ACCESS and DONE -> MAR and MDR unchanged, no second access.
REQ-040 Reset mid-access: Reset_n=0 in the 2nd ACCESS cycle -> all outputs 0 immediately, no Done pulse; a read after release completes normally.

Source files
------------

// File: rtl/mem_ctrl_unit.sv
// ---------------------------------------------------------------------------
// mem_ctrl_unit
// Memory-access controller for a small datapath. Holds the memory address
// register (MAR) and memory data register (MDR), and runs one read or write
// access at a time through a three-state machine: IDLE -> ACCESS -> DONE.
// A wait counter bounds the ACCESS phase at MAX_WAIT cycles; an access that
// runs out of cycles finishes with the sticky Err flag set.
// ---------------------------------------------------------------------------
module mem_ctrl_unit #(
    parameter int MAX_WAIT = 8   // ACCESS cycles allowed before timeout, 1..255
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] Bus_In,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        Mem_Req,
    input  logic        Mem_Wr,
    input  logic [15:0] Mem_RData,
    input  logic        Mem_Ready,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic [15:0] Mem_Addr,
    output logic [15:0] Mem_WData,
    output logic        Mem_CE,
    output logic        Mem_WE,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Counter value seen in the last permitted ACCESS cycle.
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_e      state_q;
    logic        op_q;        // 1 = write, 0 = read; latched at request
    logic [7:0]  cnt_q;       // ACCESS cycles already spent waiting
    logic        err_q;
    logic        done_q;
    logic        busy_q;
    logic        ce_q;
    logic        we_q;

    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;

    logic        in_idle;
    logic        read_capture;

    assign in_idle      = (state_q == IDLE);
    assign read_capture = (state_q == ACCESS) && Mem_Ready && !op_q;

    // Next value of MAR/MDR: bus loads only in IDLE, read data only at read completion.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        mar_d = mar_q;
        mdr_d = mdr_q;
        if (in_idle && LD_MAR) begin
            mar_d = Bus_In;
        end
        if (in_idle && LD_MDR) begin
            mdr_d = Bus_In;
        end else if (read_capture) begin
            mdr_d = Mem_RData;
        end
    end

    // MAR/MDR registers; a reset (including mid-access) clears both.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            mar_q <= 16'h0000;
            mdr_q <= 16'h0000;
        end else begin
            mar_q <= mar_d;
            mdr_q <= mdr_d;
        end
    end

    // Access FSM with registered strobes; a request in IDLE uses MAR/MDR as loaded on the same edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Mem_Req) begin
                        state_q <= ACCESS;
                        op_q    <= Mem_Wr;
                        err_q   <= 1'b0;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b1;
                        ce_q    <= 1'b1;
                        we_q    <= Mem_Wr;
                    end
                end

                ACCESS: begin
                    if (Mem_Ready) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        ce_q    <= 1'b0;
                        we_q    <= 1'b0;
                    end else if (cnt_q == LAST_WAIT) begin
                        // Out of wait cycles: finish without touching MDR.
                        state_q <= DONE;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        ce_q    <= 1'b0;
                        we_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ce_q    <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign MAR       = mar_q;
    assign MDR       = mdr_q;
    assign Mem_Addr  = mar_q;
    assign Mem_WData = mdr_q;
    assign Mem_CE    = ce_q;
    assign Mem_WE    = we_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Err       = err_q;

endmodule
